// File: rtl/dunit_step_ctrl.sv
// dunit_step_ctrl: decodes UART run/step/dump commands, gates the pipeline clock enable and streams a latch snapshot frame
module dunit_step_ctrl #(
  parameter int NB_REG  = 32,
  parameter int NB_CTRL = 4,
  parameter int NB_ADDR = 5,
  parameter int NB_BYTE = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  input  logic               i_halt,
  input  logic [NB_REG-1:0]  i_pc_eight,
  input  logic [NB_REG-1:0]  i_read_data,
  input  logic [NB_REG-1:0]  i_alu_res,
  input  logic [NB_ADDR-1:0] i_data_addr,
  input  logic [NB_CTRL-1:0] i_control,
  output logic               o_dunit_clk_en,
  output logic               o_busy
);
  localparam int FW = 3*NB_REG + 2*NB_BYTE;
  localparam int NF = FW / NB_BYTE;
  localparam int IW = $clog2(NF);
  localparam logic [NB_BYTE-1:0] CMD_C = NB_BYTE'(8'h43);
  localparam logic [NB_BYTE-1:0] CMD_S = NB_BYTE'(8'h53);
  localparam logic [NB_BYTE-1:0] CMD_D = NB_BYTE'(8'h44);
  typedef enum logic [2:0] {IDLE, RUN, STEP, CAPTURE, SEND, WAIT_TX} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [FW-1:0] frame_q, frame_d;
  logic is_c, is_s, is_d, last;
  assign is_c = i_rx_data == CMD_C;
  assign is_s = i_rx_data == CMD_S;
  assign is_d = i_rx_data == CMD_D;
  assign last = idx_q == IW'(NF-1);
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
    end
  end
  // the frame shifts left one byte per completed transfer, so the byte on air is always the top byte
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    case (state_q)
      IDLE: if (i_rx_valid && (is_c || is_s || is_d))
        state_d = (is_d || i_halt) ? CAPTURE : (is_c ? RUN : STEP);
      RUN:  state_d = i_halt ? CAPTURE : RUN;
      STEP: state_d = CAPTURE;
      CAPTURE: begin
        state_d = SEND;
        idx_d   = '0;
        frame_d = {i_pc_eight, i_read_data, i_alu_res, NB_BYTE'(i_data_addr), NB_BYTE'(i_control)};
      end
      SEND: state_d = WAIT_TX;
      WAIT_TX: if (i_tx_done) begin
        state_d = last ? IDLE : SEND;
        idx_d   = last ? '0 : idx_q + 1'b1;
        frame_d = frame_q << NB_BYTE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign o_dunit_clk_en = (state_q == RUN) || (state_q == STEP);
  assign o_tx_start     = state_q == SEND;
  assign o_busy         = state_q != IDLE;
  assign o_tx_data      = frame_q[FW-1 -: NB_BYTE];
endmodule
